// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control unit: Moore FSM sequencing PC/IR/memory/ALU/regfile plus a retired-instruction counter.
// Optional feature macro MC_ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state instead of retiring as NOPs.
module mc_ctrl_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_rdy,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_c;

  // State and retirement counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; retire_c marks instruction completion on the return to FETCH
  always_comb begin
    state_d  = S_IDLE;
    retire_c = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d  = S_FETCH;
            retire_c = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_MEMWR: begin
        state_d  = mem_rdy ? S_FETCH : S_MEMWR;
        retire_c = mem_rdy;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Moore output decode; FETCH gates PC/IR loads with mem_rdy so a stall leaves them untouched
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_rdy;
        ir_write  = mem_rdy;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:   illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (counter width reduced to 8 to exercise wrap).
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_rdy;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [7:0] instr_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_cnt;

  mc_ctrl_fsm #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_rdy(mem_rdy),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_cnt(instr_cnt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal}
  logic [16:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};

  localparam logic [16:0] O_IDLE = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_FETR = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] O_FETS = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] O_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] O_MADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] O_MRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_MWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] O_MWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] O_EXEC = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] O_ALWB = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] O_BR   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] O_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] O_AWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] O_TRAP = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  task automatic test_reset();
    rst_n = 1'b1; op = OP_R; mem_rdy = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (state !== 4'd0 || outs !== O_IDLE || instr_cnt !== 8'd0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d] state=%0d outs=%b cnt=%0d, want state=0 outs=%b cnt=0", i, state, outs, instr_cnt, O_IDLE);
      end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tests_run++;
    if (state !== 4'd0 || outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL reset_idle state=%0d outs=%b, want state=0 outs=%b", state, outs, O_IDLE);
    end
    @(posedge clk); #1;
    exp_cnt = 8'd0;
    tests_run++;
    if (state !== 4'd1 || outs !== O_FETR || instr_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL reset_fetch state=%0d outs=%b cnt=%0d, want state=1 outs=%b cnt=0", state, outs, instr_cnt, O_FETR);
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  st [4] = '{4'd1, 4'd2, 4'd7, 4'd8};
    logic [16:0] ex [4] = '{O_FETR, O_DEC, O_EXEC, O_ALWB};
    op = OP_R;
    for (int i = 0; i < 4; i++) begin
      mem_rdy = 1'b1; #1;
      tests_run++;
      if (state !== st[i] || outs !== ex[i]) begin
        tests_failed++;
        $display("FAIL rtype[%0d] state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 8'd1;
    tests_run++;
    if (state !== 4'd1 || instr_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL rtype_end state=%0d cnt=%0d, want state=1 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0]  st [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
    logic        rd [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [16:0] ex [7] = '{O_FETR, O_DEC, O_MADR, O_MRD, O_MRD, O_MRD, O_MWB};
    op = OP_LW;
    for (int i = 0; i < 7; i++) begin
      mem_rdy = rd[i]; #1;
      tests_run++;
      if (state !== st[i] || outs !== ex[i]) begin
        tests_failed++;
        $display("FAIL lw[%0d] state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 8'd1;
    tests_run++;
    if (state !== 4'd1 || instr_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL lw_end state=%0d cnt=%0d, want state=1 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_fetch_stall();
    logic [3:0]  st [7] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd7, 4'd8};
    logic        rd [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [16:0] ex [7] = '{O_FETS, O_FETS, O_FETS, O_FETR, O_DEC, O_EXEC, O_ALWB};
    op = OP_R;
    for (int i = 0; i < 7; i++) begin
      mem_rdy = rd[i]; #1;
      tests_run++;
      if (state !== st[i] || outs !== ex[i]) begin
        tests_failed++;
        $display("FAIL fstall[%0d] state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 8'd1;
    tests_run++;
    if (state !== 4'd1 || instr_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL fstall_end state=%0d cnt=%0d, want state=1 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  // sw (with one MEMWR stall), beq, j issued back to back
  task automatic test_back_to_back();
    logic [3:0]  st [11] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10};
    logic        rd [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [5:0]  ov [11] = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J};
    logic [16:0] ex [11] = '{O_FETR, O_DEC, O_MADR, O_MWR, O_MWR, O_FETR, O_DEC, O_BR, O_FETR, O_DEC, O_JMP};
    for (int i = 0; i < 11; i++) begin
      mem_rdy = rd[i]; op = ov[i]; #1;
      tests_run++;
      if (state !== st[i] || outs !== ex[i]) begin
        tests_failed++;
        $display("FAIL b2b[%0d] state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 8'd3;
    tests_run++;
    if (state !== 4'd1 || instr_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL b2b_end state=%0d cnt=%0d, want state=1 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_addi();
    logic [3:0]  st [4] = '{4'd1, 4'd2, 4'd11, 4'd12};
    logic [16:0] ex [4] = '{O_FETR, O_DEC, O_MADR, O_AWB};
    op = OP_ADDI;
    for (int i = 0; i < 4; i++) begin
      mem_rdy = 1'b1; #1;
      tests_run++;
      if (state !== st[i] || outs !== ex[i]) begin
        tests_failed++;
        $display("FAIL addi[%0d] state=%0d outs=%b, want state=%0d outs=%b", i, state, outs, st[i], ex[i]);
      end
      @(posedge clk); #1;
    end
    exp_cnt = exp_cnt + 8'd1;
    tests_run++;
    if (state !== 4'd1 || instr_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL addi_end state=%0d cnt=%0d, want state=1 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  // 252 jumps push the 8-bit counter past 255
  task automatic test_cnt_wrap();
    op = OP_J; mem_rdy = 1'b1;
    for (int i = 0; i < 252; i++) repeat (3) @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 8'd252;
    tests_run++;
    if (state !== 4'd1 || instr_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL cnt_wrap state=%0d cnt=%0d, want state=1 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    op = OP_BAD; mem_rdy = 1'b1; #1;
    tests_run++;
    if (state !== 4'd1 || outs !== O_FETR) begin
      tests_failed++;
      $display("FAIL illegal_fetch state=%0d outs=%b, want state=1 outs=%b", state, outs, O_FETR);
    end
    @(posedge clk); #1;
    tests_run++;
    if (state !== 4'd2 || outs !== O_DEC) begin
      tests_failed++;
      $display("FAIL illegal_decode state=%0d outs=%b, want state=2 outs=%b", state, outs, O_DEC);
    end
    @(posedge clk); #1;
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (state !== 4'd13 || outs !== O_TRAP || instr_cnt !== exp_cnt) begin
        tests_failed++;
        $display("FAIL trap[%0d] state=%0d outs=%b cnt=%0d, want state=13 outs=%b cnt=%0d", i, state, outs, instr_cnt, O_TRAP, exp_cnt);
      end
      @(posedge clk); #1;
    end
`else
    exp_cnt = exp_cnt + 8'd1;
    tests_run++;
    if (state !== 4'd1 || outs !== O_FETR || instr_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL illegal_nop state=%0d outs=%b cnt=%0d, want state=1 outs=%b cnt=%0d", state, outs, instr_cnt, O_FETR, exp_cnt);
    end
`endif
  endtask

  // Restart, run an R-type into ALUWB, then pull reset mid-cycle
  task automatic test_reset_mid();
    logic [3:0] st [4] = '{4'd1, 4'd2, 4'd7, 4'd8};
    rst_n = 1'b0; op = OP_R; mem_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (state !== st[i] || instr_cnt !== exp_cnt) begin
        tests_failed++;
        $display("FAIL rmid_seq[%0d] state=%0d cnt=%0d, want state=%0d cnt=%0d", i, state, instr_cnt, st[i], exp_cnt);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    tests_run++;
    if (reg_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_wr_pre reg_write=%b, want 1", reg_write);
    end
    #1 rst_n = 1'b0; #1;
    tests_run++;
    if (reg_write !== 1'b0 || state !== 4'd0 || outs !== O_IDLE) begin
      tests_failed++;
      $display("FAIL rmid_drop reg_write=%b state=%0d outs=%b, want 0 0 %b", reg_write, state, outs, O_IDLE);
    end
    @(posedge clk); #1;
    tests_run++;
    if (state !== 4'd0 || instr_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL rmid_hold state=%0d cnt=%0d, want state=0 cnt=0", state, instr_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_fetch_stall();
    test_back_to_back();
    test_addi();
    test_cnt_wrap();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
